dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the pipeline's data-memory request interface: accepts one load/store request at a time from the Memory stage.
//  Holds it for a programmable wait latency, then commits the write or reads the word.
//  Returns a response under a valid/ready handshake.
//  Replaces the zero-latency data RAM, so the core can be exercised against slow memory and back-pressure.
// PARAMETERS
//  ADDR_WIDTH   32    byte-address width of req_addr
//  DEPTH_WORDS  1024  number of 32-bit words stored; word index = req_addr[ADDR_WIDTH-1:2]
//  LATENCY      2     wait cycles between request accept and response valid (0..15)
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           asynchronous, active-high reset
//  req_valid  in   1           request present
//  req_ready  out  1           responder can accept a request this cycle
//  req_write  in   1           1 = store, 0 = load
//  req_addr   in   ADDR_WIDTH  byte address; bits [1:0] ignored for word select
//  req_wdata  in   32          store data, lane-aligned
//  req_be     in   4           byte enables; bit i writes req_wdata[8i+7:8i]
//  rsp_valid  out  1           response present
//  rsp_ready  in   1           requester consumes response
//  rsp_rdata  out  32          load data (0 for stores and errors)
//  rsp_err    out  1           address out of range
//  busy       out  1           transaction in flight (state != IDLE)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0.
//    Storage array is not cleared.
//    req_ready=1 from the first clock after rst deasserts.
//  FSM states: IDLE, WAIT, RESP.
//  IDLE:
//    - req_ready=1.
//    - On req_valid: latch write/addr/wdata/be and load counter=LATENCY.
//    - Go to WAIT if LATENCY>0, else straight to RESP.
//  WAIT:
//    - req_ready=0.
//    - Counter decrements each cycle; when counter==1, next state is RESP.
//  Commit point (edge entering RESP), all on that same edge:
//    - Range check: latched word index >= DEPTH_WORDS -> rsp_err=1, no write, rsp_rdata=0.
//    - Else store: write only enabled bytes, rsp_rdata=0.
//    - Else load: rsp_rdata=mem[index], all 4 bytes regardless of req_be.
//  RESP:
//    - rsp_valid=1; rsp_rdata/rsp_err held stable while rsp_ready=0.
//    - On rsp_ready: next state IDLE, rsp_valid=0, rsp_rdata/rsp_err cleared.
//    - No new request is accepted in the same cycle.
//  Latency: rsp_valid rises LATENCY+1 cycles after the accept edge.
//    With rsp_ready tied high, throughput is one transaction per LATENCY+2 cycles.
//  req_be=0 on a store: legal; no bytes change, normal response.
//  Requester changing req_* after accept has no effect (latched copy used).
//  Reset mid-WAIT: the pending store is dropped (memory unchanged) and no response is issued.
//  Reset in RESP: the store is already committed; the response is discarded.
//  Counter width: 4 bits; LATENCY>15 is a parameter error (elaboration check).
// STRUCTURE
//  Shared package (dmem_pkg): FSM state encoding (IDLE/WAIT/RESP), BE_WIDTH=4, WORD_BYTES=4, LAT_CNT_W=4.
//  Sub-module dmem_byte_ram: DEPTH_WORDS x 4 byte-lane RAM.
//    - Synchronous write with per-lane enable.
//    - Registered read port.
//    - Read and write to the same address on the same edge return old data.
//  Top level holds the FSM, request latch, wait counter, range check and response register.
// TESTING
//  1. LATENCY=2: store addr 0x10 data 0xDEADBEEF be=4'hF, then load 0x10.
//     -> store rsp 3 cycles after accept with err=0; load returns 0xDEADBEEF.
//  2. Partial store: be=4'b0010 data 0x0000AB00 to 0x10.
//     -> load returns 0xDEADABEF; be=0 store leaves word unchanged.
//  3. Back-pressure: hold rsp_ready=0 for 5 cycles.
//     -> rsp_valid and rsp_rdata stable; req_ready=0 throughout; one cycle after rsp_ready=1, req_ready=1.
//  4. Out of range: load/store at byte addr 4*DEPTH_WORDS (0x1000).
//     -> rsp_err=1, rdata=0, and word 0 is not aliased or corrupted.
//  5. LATENCY=0 build: req_valid held high with rsp_ready=1.
//     -> response 1 cycle after accept; accepts occur every 2nd cycle.
//  6. Reset mid-WAIT during a store to 0x20 holding 0x12345678.
//     -> all outputs 0 asynchronously; later load of 0x20 returns 0x12345678.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and lane/counter widths.
package dmem_pkg;

   localparam int BE_WIDTH   = 4;
   localparam int WORD_BYTES = 4;
   localparam int LAT_CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmemState_t;

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-addressed RAM with per-byte write enables and a registered read port.
// Read and write of the same word on one edge returns the old contents.
module dmem_byte_ram
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                   clk,
   input  logic                   wrEn,
   input  logic                   rdEn,
   input  logic [IDX_W-1:0]       addr,
   input  logic [BE_WIDTH-1:0]    be,
   input  logic [8*WORD_BYTES-1:0] wdata,
   output logic [8*WORD_BYTES-1:0] rdata
);

   logic [WORD_BYTES-1:0][7:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (rdEn) begin
         rdata <= mem[addr];
      end
      if (wrEn) begin
         for (int b = 0; b < WORD_BYTES; b++) begin
            if (be[b]) begin
               mem[addr][b] <= wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accept, wait LATENCY cycles, commit, respond.
// Response valid LATENCY+1 cycles after the accept cycle; held until rsp_ready, no accept meanwhile.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [BE_WIDTH-1:0]   req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam int IDX_W  = $clog2(DEPTH_WORDS);
   localparam int WIDX_W = ADDR_WIDTH - 2;
   localparam logic [WIDX_W-1:0]    DEPTH_LIM = WIDX_W'(DEPTH_WORDS);
   localparam logic [LAT_CNT_W-1:0] LAT_LOAD  = LAT_CNT_W'(LATENCY);
   localparam logic [LAT_CNT_W-1:0] CNT_ONE   = LAT_CNT_W'(1);
   localparam bit ZERO_LAT = (LATENCY == 0);

   if (LATENCY < 0 || LATENCY > (1 << LAT_CNT_W) - 1) begin : gLatRangeCheck
      $error("dmem_responder: LATENCY must be within 0..15");
   end

   dmemState_t            state;
   logic [LAT_CNT_W-1:0]  waitCnt;
   logic                  latWrite;
   logic [WIDX_W-1:0]     latIdx;
   logic [31:0]           latWdata;
   logic [BE_WIDTH-1:0]   latBe;
   logic                  loadRsp;
   logic [31:0]           ramRdata;

   logic                  accept;
   logic                  commit;
   logic                  cWrite;
   logic [WIDX_W-1:0]     cIdx;
   logic [31:0]           cWdata;
   logic [BE_WIDTH-1:0]   cBe;
   logic                  inRange;
   logic                  unusedAddrLsbs;

   assign unusedAddrLsbs = ^req_addr[1:0];

   assign accept = (state == IDLE) && req_ready && req_valid;

   // With zero latency the commit shares the accept edge, so it must use the live request.
   assign commit  = ZERO_LAT ? accept : ((state == WAIT) && (waitCnt == CNT_ONE));
   assign cWrite  = ZERO_LAT ? req_write                      : latWrite;
   assign cIdx    = ZERO_LAT ? req_addr[ADDR_WIDTH-1:2]       : latIdx;
   assign cWdata  = ZERO_LAT ? req_wdata                      : latWdata;
   assign cBe     = ZERO_LAT ? req_be                         : latBe;
   assign inRange = (cIdx < DEPTH_LIM);

   dmem_byte_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) uRam (
      .clk   (clk),
      .wrEn  (commit && cWrite && inRange),
      .rdEn  (commit && !cWrite && inRange),
      .addr  (cIdx[IDX_W-1:0]),
      .be    (cBe),
      .wdata (cWdata),
      .rdata (ramRdata)
   );

   // The RAM output only moves on a committed load, so gating it keeps rdata stable under back-pressure.
   assign rsp_rdata = loadRsp ? ramRdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         waitCnt   <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         loadRsp   <= 1'b0;
         busy      <= 1'b0;
         latWrite  <= 1'b0;
         latIdx    <= '0;
         latWdata  <= '0;
         latBe     <= '0;
      end else begin
         if (commit) begin
            rsp_err <= !inRange;
            loadRsp <= !cWrite && inRange;
         end
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  latWrite  <= req_write;
                  latIdx    <= req_addr[ADDR_WIDTH-1:2];
                  latWdata  <= req_wdata;
                  latBe     <= req_be;
                  waitCnt   <= LAT_LOAD;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (ZERO_LAT) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               waitCnt <= waitCnt - CNT_ONE;
               if (waitCnt == CNT_ONE) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  loadRsp   <= 1'b0;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main sequence and a LATENCY=0 instance for throughput.
module tb_dmem_responder;

   localparam int LAT = 2;

   logic        clk;
   logic        rst;

   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_ready, rsp_err, busy;
   logic [31:0] rsp_rdata;

   logic        req_valid0, req_ready0, req_write0;
   logic [31:0] req_addr0, req_wdata0;
   logic [3:0]  req_be0;
   logic        rsp_valid0, rsp_ready0, rsp_err0, busy0;
   logic [31:0] rsp_rdata0;

   int vectors;
   int miscompares;
   logic [32:0] expQ [$];

   dmem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy)
   );

   dmem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
      .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
      .rsp_err(rsp_err0), .busy(busy0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on the LATENCY=2 instance, optionally stalling the response for 'hold' cycles.
   task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] expD, input logic expE,
                       input int hold);
      int n;
      logic [32:0] exp;
      expQ.push_back({expE, expD});
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("reqReadyBeforeAccept", req_ready, 1);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
      tick();
      req_valid = 1'b0; req_write = ~wr; req_addr = addr ^ 32'h4; req_wdata = ~wd; req_be = ~be;
      n = 1;
      while (rsp_valid !== 1'b1 && n < 30) begin
         check("reqReadyWhileWaiting", req_ready, 0);
         tick();
         n++;
      end
      check("rspLatency", n, LAT + 1);
      exp = expQ.pop_front();
      for (int i = 0; i < hold; i++) begin
         check("bpRspValid", rsp_valid, 1);
         check("bpRspData", {rsp_err, rsp_rdata}, exp);
         check("bpReqReady", req_ready, 0);
         tick();
      end
      check("rspData", {rsp_err, rsp_rdata}, exp);
      check("rspBusy", busy, 1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("postRspValid", rsp_valid, 0);
      check("postRspData", {rsp_err, rsp_rdata}, 33'h0);
      check("postReqReady", req_ready, 1);
      check("postBusy", busy, 0);
   endtask

   initial begin
      int n;
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
      req_valid0 = 0; req_write0 = 0; req_addr0 = 0; req_wdata0 = 0; req_be0 = 0; rsp_ready0 = 0;

      #12;
      check("rstReqReady", req_ready, 0);
      check("rstRspValid", rsp_valid, 0);
      check("rstRspData", {rsp_err, rsp_rdata}, 33'h0);
      check("rstBusy", busy, 0);
      check("rstReqReady0", req_ready0, 0);
      rst = 1'b0;
      tick();
      check("firstReqReady", req_ready, 1);

      // Full store then load, load with a single be bit still returns the whole word.
      xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
      xact(1'b0, 32'h10, 32'h0, 4'h1, 32'hDEADBEEF, 1'b0, 0);
      // Partial store and empty-enable store.
      xact(1'b1, 32'h10, 32'h0000AB00, 4'b0010, 32'h0, 1'b0, 0);
      xact(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADABEF, 1'b0, 0);
      xact(1'b1, 32'h10, 32'h11111111, 4'h0, 32'h0, 1'b0, 0);
      xact(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADABEF, 1'b0, 5);
      // Out of range must not alias onto word 0.
      xact(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 0);
      xact(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0);
      xact(1'b0, 32'h1000, 32'h0, 4'hF, 32'h0, 1'b1, 2);
      xact(1'b0, 32'h0, 32'h0, 4'hF, 32'hA5A5A5A5, 1'b0, 0);
      // Last valid word, with ignored low address bits on the load.
      xact(1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 0);
      xact(1'b0, 32'hFFE, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, 0);
      xact(1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0, 1'b0, 0);

      // Reset during WAIT drops the pending store.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
      tick();
      req_valid = 1'b0;
      check("midWaitBusy", busy, 1);
      rst = 1'b1;
      #1;
      check("asyncRstReqReady", req_ready, 0);
      check("asyncRstRspValid", rsp_valid, 0);
      check("asyncRstRspData", {rsp_err, rsp_rdata}, 33'h0);
      check("asyncRstBusy", busy, 0);
      tick();
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("reqReadyAfterRst", req_ready, 1);
      check("noRspAfterRst", rsp_valid, 0);
      xact(1'b0, 32'h20, 32'h0, 4'hF, 32'h12345678, 1'b0, 0);

      // Zero-latency instance: held request with rsp_ready high alternates accept and response.
      rsp_ready0 = 1'b1; req_write0 = 1'b1; req_addr0 = 32'h40; req_be0 = 4'hF; req_wdata0 = 32'h0;
      req_valid0 = 1'b1;
      n = 0;
      while (req_ready0 !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      for (int i = 0; i < 8; i++) begin
         check("lat0ReqReady", req_ready0, (i % 2 == 0));
         check("lat0RspValid", rsp_valid0, (i % 2 == 1));
         if (i % 2 == 1) check("lat0StoreRsp", {rsp_err0, rsp_rdata0}, 33'h0);
         if (i % 2 == 0) req_wdata0 = 32'h100 + i;
         tick();
      end
      check("lat0ReqReadyLoad", req_ready0, 1);
      req_write0 = 1'b0;
      tick();
      req_valid0 = 1'b0;
      check("lat0LoadValid", rsp_valid0, 1);
      check("lat0LoadData", {rsp_err0, rsp_rdata0}, {1'b0, 32'h106});
      tick();
      check("lat0Idle", rsp_valid0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
